receptor_serie: RTL and testbench
=================================

// Module: receptor_serie
// PURPOSE
//  Serial-to-parallel frame receiver: the receive end of the serial link driven by the 4-bit
//  shift register's s_out. Detects start bit, deserializes WIDTH data bits in either bit order,
//  checks optional even parity and stop bit, presents the word on q with a one-cycle valid pulse.
//  Sits between the shifting register/line and downstream word consumers.
// PARAMETERS
//  WIDTH      4  data bits per frame (>=2)
//  PARITY_EN  1  1: frame carries even-parity bit after data; 0: no parity bit
// PORTS
//  clk         in   1      clock, all state changes on posedge
//  rst_n       in   1      asynchronous reset, active low
//  enb         in   1      bit strobe; s_in sampled only on posedge with enb=1
//  dir         in   1      bit order: 0 = MSB first (left shift), 1 = LSB first (right shift)
//  s_in        in   1      serial line, idles high
//  q           out  WIDTH  last accepted word
//  valid       out  1      1-cycle pulse: q updated with a new word
//  parity_err  out  1      1-cycle pulse with valid: parity mismatch
//  frame_err   out  1      1-cycle pulse: stop bit sampled 0
//  busy        out  1      frame in progress
// BEHAVIOUR
//  - Reset (async, any state): q=0, valid=0, parity_err=0, frame_err=0, busy=0, state IDLE,
//    bit counter=0, shift buffer=0. Mid-frame reset discards the partial frame.
//  - Frame: start(0), WIDTH data bits, parity bit (if PARITY_EN), stop(1). One bit per enb cycle.
//  - Cycles with enb=0: all state, counter, buffer held; pulses still self-clear.
//  - States: IDLE -> DATA -> PARITY -> STOP -> IDLE (PARITY skipped when PARITY_EN=0).
//  - IDLE: enb & s_in=0 -> DATA, cnt=0, busy=1, dir latched into dir_r. enb & s_in=1 -> stay.
//  - DATA: per enb: dir_r=0: buf <= {buf[WIDTH-2:0], s_in}; dir_r=1: buf <= {s_in, buf[WIDTH-1:1]};
//    cnt++; on WIDTH-th bit -> PARITY (or STOP). dir changes mid-frame are ignored.
//  - PARITY: per enb: p_r <= s_in -> STOP.
//  - STOP: per enb: s_in=1 -> q<=buf, valid=1, parity_err = PARITY_EN & (^buf ^ p_r);
//    s_in=0 -> frame_err=1, q held, valid=0. Either way -> IDLE, busy=0.
//  - Latency: valid/parity_err/frame_err/q visible in the cycle after the posedge that samples
//    the stop bit; pulses last exactly one clk regardless of enb.
//  - A word with parity error is still loaded into q (valid=1 and parity_err=1 together).
//  - Back-to-back: a start bit on the enb cycle right after stop is accepted (IDLE is entered on
//    the stop sample, so next enb with s_in=0 starts a frame). No gap bit required.
//  - frame_err and valid never both 1. busy=0 whenever state is IDLE.
// TESTING (WIDTH=4, PARITY_EN=1, enb=1 unless stated)
//  1 dir=0, bits 0,1,0,1,1,p=1,stop=1 -> q=4'b1011, valid 1 clk, parity_err=0, busy high 6 clks.
//  2 dir=1, same bits -> q=4'b1101, valid 1 clk, parity_err=0; dir toggled mid-frame no effect.
//  3 dir=0, bits 0,1,0,1,1,p=0,stop=1 -> q=4'b1011, valid=1 and parity_err=1 same cycle.
//  4 after q=1011, frame 0,0,1,1,0,p=0,stop=0 -> frame_err 1 clk, valid=0, q stays 4'b1011.
//  5 enb high only every 3rd clk, frame of case 1 plus immediate second frame 0,1,1,1,1,p=0,1
//    -> q=1011 then q=1111, two valid pulses, no errors.
//  6 rst_n low after 2 data bits -> all outputs 0 immediately; after release, full frame of
//    case 1 -> q=4'b1011 with no residue from aborted frame.

Source files
------------

// File: rtl/receptor_serie_if.sv
// Serial receiver link bundle: bit strobe/line/order in, deserialized word and status out.
interface receptor_serie_if #(
  parameter int WIDTH = 4
);
  logic             enb;
  logic             dir;
  logic             s_in;
  logic [WIDTH-1:0] q;
  logic             valid;
  logic             parity_err;
  logic             frame_err;
  logic             busy;

  modport master (
    output enb, dir, s_in,
    input  q, valid, parity_err, frame_err, busy
  );

  modport slave (
    input  enb, dir, s_in,
    output q, valid, parity_err, frame_err, busy
  );
endinterface

// File: rtl/receptor_serie.sv
// Serial-to-parallel frame receiver: start bit, WIDTH data bits in either order,
// optional even parity, stop bit; word presented on q with one-cycle valid pulse.
module receptor_serie #(
  parameter int WIDTH     = 4,
  parameter int PARITY_EN = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  receptor_serie_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_buf;
  logic [WIDTH-1:0]   r_q;
  logic               r_dir;
  logic               r_par;
  logic               r_valid;
  logic               r_parity_err;
  logic               r_frame_err;
  logic               r_busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_buf        <= '0;
      r_q          <= '0;
      r_dir        <= 1'b0;
      r_par        <= 1'b0;
      r_valid      <= 1'b0;
      r_parity_err <= 1'b0;
      r_frame_err  <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      // Status pulses clear every clock, independent of the bit strobe.
      r_valid      <= 1'b0;
      r_parity_err <= 1'b0;
      r_frame_err  <= 1'b0;
      if (bus.enb) begin
        case (r_state)
          IDLE: begin
            if (!bus.s_in) begin
              r_state <= DATA;
              r_cnt   <= '0;
              r_busy  <= 1'b1;
              r_dir   <= bus.dir;
            end
          end
          DATA: begin
            if (r_dir) r_buf <= {bus.s_in, r_buf[WIDTH-1:1]};
            else       r_buf <= {r_buf[WIDTH-2:0], bus.s_in};
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == CNT_W'(WIDTH - 1)) begin
              if (PARITY_EN != 0) r_state <= PARITY;
              else                r_state <= STOP;
            end
          end
          PARITY: begin
            r_par   <= bus.s_in;
            r_state <= STOP;
          end
          STOP: begin
            if (bus.s_in) begin
              r_q          <= r_buf;
              r_valid      <= 1'b1;
              r_parity_err <= (PARITY_EN != 0) && ((^r_buf) ^ r_par);
            end else begin
              r_frame_err  <= 1'b1;
            end
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
          default: begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.q          = r_q;
  assign bus.valid      = r_valid;
  assign bus.parity_err = r_parity_err;
  assign bus.frame_err  = r_frame_err;
  assign bus.busy       = r_busy;

endmodule

// File: tb/tb_receptor_serie.sv
// Directed bench for receptor_serie (WIDTH=4, even parity enabled).
module tb_receptor_serie;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;
  int   busy_cnt;

  receptor_serie_if #(.WIDTH(4)) bus ();

  receptor_serie #(
    .WIDTH     (4),
    .PARITY_EN (1)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check1(input string tag, input logic obs, input logic exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic checki(input string tag, input int obs, input int exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One serial bit; slow mode idles two clocks with enb=0 first (enb every 3rd clock).
  task automatic send_bit(input logic b, input bit slow);
    if (slow) begin
      bus.enb = 1'b0;
      repeat (2) begin
        @(posedge clk);
        #1;
      end
    end
    bus.enb  = 1'b1;
    bus.s_in = b;
    @(posedge clk);
    #1;
    if (bus.busy) busy_cnt++;
    if (slow) bus.enb = 1'b0;
  endtask

  // Start bit, d[3]..d[0] in time order, parity, stop. Returns #1 after the stop sample.
  task automatic send_frame(input logic [3:0] d, input logic p, input logic stp,
                            input bit slow, input bit toggle_dir);
    busy_cnt = 0;
    send_bit(1'b0, slow);
    for (int i = 3; i >= 0; i--) begin
      send_bit(d[i], slow);
      if (toggle_dir) bus.dir = ~bus.dir;
    end
    send_bit(p, slow);
    send_bit(stp, slow);
    bus.s_in = 1'b1;
  endtask

  initial begin
    n_vec    = 0;
    n_err    = 0;
    busy_cnt = 0;
    rst_n    = 1'b0;
    bus.enb  = 1'b0;
    bus.dir  = 1'b0;
    bus.s_in = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check4("rst_q", bus.q, 4'b0000);
    check1("rst_valid", bus.valid, 1'b0);
    check1("rst_busy", bus.busy, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Idle line with strobes: stays idle
    bus.enb = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check1("idle_busy", bus.busy, 1'b0);

    // 1: MSB first, good parity
    send_frame(4'b1011, 1'b1, 1'b1, 1'b0, 1'b0);
    check4("c1_q", bus.q, 4'b1011);
    check1("c1_valid", bus.valid, 1'b1);
    check1("c1_perr", bus.parity_err, 1'b0);
    check1("c1_ferr", bus.frame_err, 1'b0);
    checki("c1_busy_clks", busy_cnt, 6);
    @(posedge clk);
    #1;
    check1("c1_valid_clr", bus.valid, 1'b0);

    // 2: LSB first, dir toggled during data bits
    bus.dir = 1'b1;
    send_frame(4'b1011, 1'b1, 1'b1, 1'b0, 1'b1);
    check4("c2_q", bus.q, 4'b1101);
    check1("c2_valid", bus.valid, 1'b1);
    check1("c2_perr", bus.parity_err, 1'b0);
    bus.dir = 1'b0;

    // 3: parity error, word still loaded
    send_frame(4'b1011, 1'b0, 1'b1, 1'b0, 1'b0);
    check4("c3_q", bus.q, 4'b1011);
    check1("c3_valid", bus.valid, 1'b1);
    check1("c3_perr", bus.parity_err, 1'b1);
    @(posedge clk);
    #1;
    check1("c3_perr_clr", bus.parity_err, 1'b0);

    // 4: stop bit 0 -> frame error, q held
    send_frame(4'b0110, 1'b0, 1'b0, 1'b0, 1'b0);
    check1("c4_ferr", bus.frame_err, 1'b1);
    check1("c4_valid", bus.valid, 1'b0);
    check4("c4_q", bus.q, 4'b1011);
    check1("c4_busy", bus.busy, 1'b0);
    @(posedge clk);
    #1;
    check1("c4_ferr_clr", bus.frame_err, 1'b0);

    // 5: strobe every third clock, back-to-back frames
    send_frame(4'b1011, 1'b1, 1'b1, 1'b1, 1'b0);
    check4("c5a_q", bus.q, 4'b1011);
    check1("c5a_valid", bus.valid, 1'b1);
    check1("c5a_perr", bus.parity_err, 1'b0);
    checki("c5a_busy_strobes", busy_cnt, 6);
    send_frame(4'b1111, 1'b0, 1'b1, 1'b1, 1'b0);
    check4("c5b_q", bus.q, 4'b1111);
    check1("c5b_valid", bus.valid, 1'b1);
    check1("c5b_perr", bus.parity_err, 1'b0);
    check1("c5b_ferr", bus.frame_err, 1'b0);
    @(posedge clk);
    #1;
    check1("c5b_valid_clr", bus.valid, 1'b0);

    // 6: reset after two data bits, then clean frame
    bus.enb = 1'b1;
    send_bit(1'b0, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    check1("c6_busy_mid", bus.busy, 1'b1);
    rst_n = 1'b0;
    #1;
    check4("c6_rst_q", bus.q, 4'b0000);
    check1("c6_rst_busy", bus.busy, 1'b0);
    check1("c6_rst_valid", bus.valid, 1'b0);
    bus.s_in = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    send_frame(4'b1011, 1'b1, 1'b1, 1'b0, 1'b0);
    check4("c6_q", bus.q, 4'b1011);
    check1("c6_valid", bus.valid, 1'b1);
    check1("c6_perr", bus.parity_err, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
